split_join_ctrl: RTL and testbench
==================================

Name: split_join_ctrl

Overview:
- Per-warp divergence controller that drives an IPDOM stack: the issue side of the stack's push/pop/pair/q1/q2 interface, and the consumer of its d/index/empty/full outputs.
- Turns branch-split and join requests from the warp scheduler into stack operations.
- Returns the new thread mask and an optional PC redirect to the scheduler.
- One instance per warp, sitting between the warp scheduler and that warp's IPDOM stack instance.

Parameters:
- NUM_THREADS, 4: threads per warp; width of thread masks.
- PC_W, 32: PC width.
- STACK_W, PC_W+NUM_THREADS (derived, not overridable): stack entry width; entry = {pc, tmask}.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_is_join_i  in  1  1 = join, 0 = split
- req_tmask_i  in  NUM_THREADS  current warp thread mask
- req_taken_i  in  NUM_THREADS  per-thread branch outcome (split only)
- req_else_pc_i  in  PC_W  not-taken PC (split only)
- resp_valid_o  out  1  one-cycle response pulse; no backpressure
- resp_tmask_o  out  NUM_THREADS  new thread mask
- resp_pc_valid_o  out  1  scheduler must redirect to resp_pc_o
- resp_pc_o  out  PC_W  redirect PC
- stk_push_o  out  1  stack push
- stk_pop_o  out  1  stack pop
- stk_pair_o  out  1  push carries a q1/q2 pair
- stk_q1_o  out  STACK_W  restore entry
- stk_q2_o  out  STACK_W  else-path entry
- stk_d_i  in  STACK_W  stack top data (synchronous read, valid one cycle after pointer change)
- stk_index_i  in  1  1 = top is restore entry, 0 = else entry
- stk_empty_i  in  1  stack empty
- stk_full_i  in  1  stack full
- err_overflow_o  out  1  sticky: divergent split while full
- err_underflow_o  out  1  sticky: join while empty

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1; FSM in IDLE; captured request and error flags cleared.
- Reset asserted mid-operation aborts immediately: no push/pop is issued, no response is produced.
- States:
  - IDLE: accept on req_valid_i & req_ready_o and register the request fields. Go to SPLIT if split, JRD if join.
  - SPLIT (1 cycle): compute taken_m = tmask & taken, else_m = tmask & ~taken.
    - Divergent = taken_m != 0 and else_m != 0.
    - Divergent and !stk_full_i: stk_push_o = 1, stk_pair_o = 1, q1 = {0, tmask}, q2 = {else_pc, else_m}; resp_tmask = taken_m.
    - Divergent and stk_full_i: no push; set err_overflow_o; resp_tmask = tmask.
    - Uniform: no push; resp_tmask = taken_m if nonzero, else tmask.
    - resp_valid_o = 1 and resp_pc_valid_o = 0 in every case. Next state IDLE.
  - JRD (1 cycle): wait for stack read data to settle. If stk_empty_i: set err_underflow_o, go to JRSP_ERR. Otherwise go to JPOP.
  - JPOP (1 cycle): stk_pop_o = 1; resp_valid_o = 1; resp_tmask = stk_d_i tmask field.
    - stk_index_i = 0: resp_pc_valid_o = 1, resp_pc = stk_d_i pc field.
    - stk_index_i = 1: resp_pc_valid_o = 0.
    - Next state IDLE.
  - JRSP_ERR: resp_valid_o = 1, resp_tmask = captured tmask, resp_pc_valid_o = 0; next state IDLE.
- Latency: split accept at T gives response at T+1; join accept at T gives response at T+2.
- Throughput: one request in flight; req_ready_o = 0 outside IDLE.
- stk_push_o and stk_pop_o are never asserted in the same cycle.
- stk_q1_o/stk_q2_o are driven only while stk_push_o = 1; otherwise 0.
- Error flags stay set until reset.

Optional Feature:
- Macro SPLIT_JOIN_PERF_EN.
- Defined: adds 32-bit outputs perf_div_splits_o (count of divergent splits actually pushed) and perf_max_depth_o (peak outstanding pair count; +1 on pair push, −1 on index-0 pop).
  - Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist; no other behaviour changes.

Decomposition:
- Shared package split_join_pkg holds:
  - typedef ipdom_entry_t {pc, tmask}
  - state enum {IDLE, SPLIT, JRD, JPOP, JRSP_ERR}
  - helper function for divergence detection.
- Sub-module split_join_perf holds the perf counters, instantiated only under SPLIT_JOIN_PERF_EN.

Test Plan:
- Uniform split: tmask=1111, taken=1111 → resp at T+1, tmask=1111, no push, pc_valid=0.
- Divergent split: tmask=1111, taken=0011, else_pc=0x100 → push pair, q1={0,1111}, q2={0x100,1100}, resp tmask=0011.
- Divergent split, then two joins:
  - First join → pop, index=0, resp pc_valid=1, pc=0x100, tmask=1100.
  - Second join → index=1, tmask=1111, pc_valid=0.
- Divergent split with stk_full_i=1 → no push, err_overflow_o=1, resp tmask=1111.
- Join with stk_empty_i=1 → no pop, err_underflow_o=1, resp at T+2 with captured tmask.
- Reset (rst_ni=0) during JRD → no pop, no resp, outputs 0, req_ready_o=1 after release.

Source files
------------

// File: rtl/split_join_pkg.sv
// Shared types for the per-warp split/join divergence controller:
// IPDOM stack entry layout, controller states and the divergence test.
package split_join_pkg;

  localparam int unsigned SJ_NUM_THREADS = 4;
  localparam int unsigned SJ_PC_W        = 32;

  typedef struct packed {
    logic [SJ_PC_W-1:0]        pc;
    logic [SJ_NUM_THREADS-1:0] tmask;
  } ipdom_entry_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPLIT    = 3'd1,
    JRD      = 3'd2,
    JPOP     = 3'd3,
    JRSP_ERR = 3'd4
  } sj_state_e;

  // Masks are zero-extended to 64 bits so one helper serves any warp width.
  function automatic logic is_divergent(input logic [63:0] taken_m, input logic [63:0] else_m);
    return (taken_m != 64'd0) && (else_m != 64'd0);
  endfunction

endpackage

// File: rtl/split_join_perf.sv
// Saturating divergence statistics: divergent splits pushed and peak
// outstanding pair depth (pair push +1, else-entry pop -1).
module split_join_perf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pair_push_i,
  input  logic        else_pop_i,
  output logic [31:0] perf_div_splits_o,
  output logic [31:0] perf_max_depth_o
);

  logic [31:0] div_q, div_d;
  logic [31:0] depth_q, depth_d;
  logic [31:0] max_q, max_d;

  // Next-value logic for the three saturating counters.
  always_comb begin
    div_d   = div_q;
    depth_d = depth_q;
    max_d   = max_q;
    if (pair_push_i && (div_q != 32'hFFFF_FFFF)) begin
      div_d = div_q + 32'd1;
    end else begin
      div_d = div_q;
    end
    if (pair_push_i && !else_pop_i && (depth_q != 32'hFFFF_FFFF)) begin
      depth_d = depth_q + 32'd1;
    end else if (else_pop_i && !pair_push_i && (depth_q != 32'd0)) begin
      depth_d = depth_q - 32'd1;
    end else begin
      depth_d = depth_q;
    end
    if (depth_d > max_q) begin
      max_d = depth_d;
    end else begin
      max_d = max_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= 32'd0;
      depth_q <= 32'd0;
      max_q   <= 32'd0;
    end else begin
      div_q   <= div_d;
      depth_q <= depth_d;
      max_q   <= max_d;
    end
  end

  assign perf_div_splits_o = div_q;
  assign perf_max_depth_o  = max_q;

endmodule

// File: rtl/split_join_ctrl.sv
// Per-warp divergence controller issuing IPDOM stack push/pop for split and
// join requests. Optional perf counters enabled by macro SPLIT_JOIN_PERF_EN.
module split_join_ctrl
  import split_join_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int PC_W        = 32,
  localparam int STACK_W     = PC_W + NUM_THREADS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_is_join_i,
  input  logic [NUM_THREADS-1:0] req_tmask_i,
  input  logic [NUM_THREADS-1:0] req_taken_i,
  input  logic [PC_W-1:0]        req_else_pc_i,
  output logic                   resp_valid_o,
  output logic [NUM_THREADS-1:0] resp_tmask_o,
  output logic                   resp_pc_valid_o,
  output logic [PC_W-1:0]        resp_pc_o,
  output logic                   stk_push_o,
  output logic                   stk_pop_o,
  output logic                   stk_pair_o,
  output logic [STACK_W-1:0]     stk_q1_o,
  output logic [STACK_W-1:0]     stk_q2_o,
  input  logic [STACK_W-1:0]     stk_d_i,
  input  logic                   stk_index_i,
  input  logic                   stk_empty_i,
  input  logic                   stk_full_i,
  output logic                   err_overflow_o,
  output logic                   err_underflow_o
`ifdef SPLIT_JOIN_PERF_EN
  ,
  output logic [31:0]            perf_div_splits_o,
  output logic [31:0]            perf_max_depth_o
`endif
);

  sj_state_e              state_q, state_d;
  logic [NUM_THREADS-1:0] tmask_q, tmask_d;
  logic [NUM_THREADS-1:0] taken_q, taken_d;
  logic [PC_W-1:0]        else_pc_q, else_pc_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   err_unf_q, err_unf_d;

  logic [NUM_THREADS-1:0] taken_m;
  logic [NUM_THREADS-1:0] else_m;
  logic                   divergent;

  assign taken_m   = tmask_q & taken_q;
  assign else_m    = tmask_q & ~taken_q;
  assign divergent = is_divergent(64'(taken_m), 64'(else_m));

  // Next-state, request capture and stack/response decode.
  always_comb begin
    state_d         = state_q;
    tmask_d         = tmask_q;
    taken_d         = taken_q;
    else_pc_d       = else_pc_q;
    err_ovf_d       = err_ovf_q;
    err_unf_d       = err_unf_q;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_tmask_o    = {NUM_THREADS{1'b0}};
    resp_pc_valid_o = 1'b0;
    resp_pc_o       = {PC_W{1'b0}};
    stk_push_o      = 1'b0;
    stk_pop_o       = 1'b0;
    stk_pair_o      = 1'b0;
    stk_q1_o        = {STACK_W{1'b0}};
    stk_q2_o        = {STACK_W{1'b0}};
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          tmask_d   = req_tmask_i;
          taken_d   = req_taken_i;
          else_pc_d = req_else_pc_i;
          state_d   = req_is_join_i ? JRD : SPLIT;
        end else begin
          state_d = IDLE;
        end
      end
      SPLIT: begin
        resp_valid_o = 1'b1;
        if (divergent && !stk_full_i) begin
          stk_push_o   = 1'b1;
          stk_pair_o   = 1'b1;
          stk_q1_o     = {{PC_W{1'b0}}, tmask_q};
          stk_q2_o     = {else_pc_q, else_m};
          resp_tmask_o = taken_m;
        end else if (divergent) begin
          err_ovf_d    = 1'b1;
          resp_tmask_o = tmask_q;
        end else begin
          resp_tmask_o = (taken_m != {NUM_THREADS{1'b0}}) ? taken_m : tmask_q;
        end
        state_d = IDLE;
      end
      // Stack read data is only trusted one cycle after the join is accepted.
      JRD: begin
        if (stk_empty_i) begin
          err_unf_d = 1'b1;
          state_d   = JRSP_ERR;
        end else begin
          state_d = JPOP;
        end
      end
      JPOP: begin
        stk_pop_o    = 1'b1;
        resp_valid_o = 1'b1;
        resp_tmask_o = stk_d_i[NUM_THREADS-1:0];
        if (!stk_index_i) begin
          resp_pc_valid_o = 1'b1;
          resp_pc_o       = stk_d_i[STACK_W-1:NUM_THREADS];
        end else begin
          resp_pc_valid_o = 1'b0;
        end
        state_d = IDLE;
      end
      JRSP_ERR: begin
        resp_valid_o = 1'b1;
        resp_tmask_o = tmask_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request and sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tmask_q   <= {NUM_THREADS{1'b0}};
      taken_q   <= {NUM_THREADS{1'b0}};
      else_pc_q <= {PC_W{1'b0}};
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmask_q   <= tmask_d;
      taken_q   <= taken_d;
      else_pc_q <= else_pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;

`ifdef SPLIT_JOIN_PERF_EN
  split_join_perf u_perf (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pair_push_i       (stk_push_o & stk_pair_o),
    .else_pop_i        (stk_pop_o & ~stk_index_i),
    .perf_div_splits_o (perf_div_splits_o),
    .perf_max_depth_o  (perf_max_depth_o)
  );
`endif

endmodule

// File: tb/tb_split_join_ctrl.sv
// Self-checking bench for split_join_ctrl with a behavioural IPDOM stack,
// table-driven split vectors, directed join/reset sequences and random traffic.
module tb_split_join_ctrl;
  import split_join_pkg::*;

  localparam int NT  = 4;
  localparam int PW  = 32;
  localparam int SW  = PW + NT;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_join = 1'b0;
  logic [NT-1:0] req_tmask = '0;
  logic [NT-1:0] req_taken = '0;
  logic [PW-1:0] req_else_pc = '0;
  logic          resp_valid;
  logic [NT-1:0] resp_tmask;
  logic          resp_pc_valid;
  logic [PW-1:0] resp_pc;
  logic          stk_push, stk_pop, stk_pair;
  logic [SW-1:0] stk_q1, stk_q2;
  logic [SW-1:0] stk_d = '0;
  logic          stk_index = 1'b0;
  logic          stk_empty, stk_full;
  logic          err_ovf, err_unf;
`ifdef SPLIT_JOIN_PERF_EN
  logic [31:0]   perf_div, perf_depth;
`endif

  always #5 clk = ~clk;

  split_join_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_join_i(req_is_join),
    .req_tmask_i(req_tmask), .req_taken_i(req_taken), .req_else_pc_i(req_else_pc),
    .resp_valid_o(resp_valid), .resp_tmask_o(resp_tmask),
    .resp_pc_valid_o(resp_pc_valid), .resp_pc_o(resp_pc),
    .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_pair_o(stk_pair),
    .stk_q1_o(stk_q1), .stk_q2_o(stk_q2), .stk_d_i(stk_d), .stk_index_i(stk_index),
    .stk_empty_i(stk_empty), .stk_full_i(stk_full),
    .err_overflow_o(err_ovf), .err_underflow_o(err_unf)
`ifdef SPLIT_JOIN_PERF_EN
    , .perf_div_splits_o(perf_div), .perf_max_depth_o(perf_depth)
`endif
  );

  // Behavioural IPDOM stack: pair push stores restore entry then else entry.
  logic [SW-1:0] stk_ent[$];
  bit            stk_idx[$];
  int            stk_size = 0;
  logic          force_full = 1'b0;
  assign stk_empty = (stk_size == 0);
  assign stk_full  = force_full || (stk_size >= CAP - 1);

  always @(posedge clk) begin
    if (stk_push && stk_pair) begin
      stk_ent.push_back(stk_q1); stk_idx.push_back(1'b1);
      stk_ent.push_back(stk_q2); stk_idx.push_back(1'b0);
    end else if (stk_pop && stk_ent.size() > 0) begin
      void'(stk_ent.pop_back()); void'(stk_idx.pop_back());
    end
    stk_size = stk_ent.size();
    if (stk_size > 0) begin
      stk_d <= stk_ent[$]; stk_index <= stk_idx[$];
    end else begin
      stk_d <= '0; stk_index <= 1'b0;
    end
  end

  int   checks = 0;
  int   errors = 0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic split_req(input logic [NT-1:0] tm, input logic [NT-1:0] tk, input logic [PW-1:0] pc,
                           input logic full, input logic exp_push, input logic [NT-1:0] exp_t,
                           input logic exp_ovf);
    logic [SW-1:0] e1, e2;
    e1 = exp_push ? {{PW{1'b0}}, tm} : '0;
    e2 = exp_push ? {pc, tm & ~tk} : '0;
    @(negedge clk);
    chk("split_ready", req_ready, 1);
    force_full = full; req_valid = 1'b1; req_is_join = 1'b0;
    req_tmask = tm; req_taken = tk; req_else_pc = pc;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("split_resp_valid", resp_valid, 1);
    chk("split_tmask", resp_tmask, exp_t);
    chk("split_pc_valid", resp_pc_valid, 0);
    chk("split_push", stk_push, exp_push);
    chk("split_pair", stk_pair, exp_push);
    chk("split_q1", stk_q1, e1);
    chk("split_q2", stk_q2, e2);
    chk("split_no_pop", stk_pop, 0);
    chk("split_busy", req_ready, 0);
    @(posedge clk); #1 force_full = 1'b0;
    chk("split_err_ovf", err_ovf, exp_ovf);
    chk("split_idle_resp", resp_valid, 0);
  endtask

  task automatic join_req(input logic [NT-1:0] tm, input logic exp_pop, input logic [NT-1:0] exp_t,
                          input logic exp_pcv, input logic [PW-1:0] exp_pc, input logic exp_unf);
    @(negedge clk);
    chk("join_ready", req_ready, 1);
    req_valid = 1'b1; req_is_join = 1'b1; req_tmask = tm;
    req_taken = NT'($urandom); req_else_pc = $urandom;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("join_t1_resp", resp_valid, 0);
    chk("join_t1_pop", stk_pop, 0);
    @(negedge clk);
    chk("join_resp_valid", resp_valid, 1);
    chk("join_pop", stk_pop, exp_pop);
    chk("join_no_push", stk_push, 0);
    chk("join_tmask", resp_tmask, exp_t);
    chk("join_pc_valid", resp_pc_valid, exp_pcv);
    chk("join_pc", resp_pc, exp_pc);
    @(posedge clk); #1;
    chk("join_err_unf", err_unf, exp_unf);
  endtask

  // Join expectation derived from the stack model contents.
  task automatic join_model(input logic [NT-1:0] tm);
    ipdom_entry_t e;
    if (stk_ent.size() == 0) begin
      m_unf = 1'b1;
      join_req(tm, 1'b0, tm, 1'b0, '0, m_unf);
    end else begin
      e = ipdom_entry_t'(stk_ent[$]);
      if (stk_idx[$]) join_req(tm, 1'b1, e.tmask, 1'b0, '0, m_unf);
      else            join_req(tm, 1'b1, e.tmask, 1'b1, e.pc, m_unf);
    end
  endtask

  typedef struct {
    logic [NT-1:0] tm, tk;
    logic [PW-1:0] pc;
    logic          full, exp_push;
    logic [NT-1:0] exp_t;
    logic          exp_ovf;
  } svec_t;
  svec_t tbl[5];

  initial begin
    tbl[0] = '{4'b1111, 4'b1111, 32'h0,   1'b0, 1'b0, 4'b1111, 1'b0};
    tbl[1] = '{4'b0101, 4'b0000, 32'h40,  1'b0, 1'b0, 4'b0101, 1'b0};
    tbl[2] = '{4'b1111, 4'b0011, 32'h100, 1'b1, 1'b0, 4'b1111, 1'b1};
    tbl[3] = '{4'b1111, 4'b0011, 32'h100, 1'b0, 1'b1, 4'b0011, 1'b1};
    tbl[4] = '{4'b0000, 4'b1010, 32'h80,  1'b0, 1'b0, 4'b0000, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_q2", stk_q2, 0);
    chk("rst_err", {err_ovf, err_unf}, 0);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      split_req(tbl[i].tm, tbl[i].tk, tbl[i].pc, tbl[i].full,
                tbl[i].exp_push, tbl[i].exp_t, tbl[i].exp_ovf);
    end
    m_ovf = 1'b1;

    // Unwind the divergent split: else path first, then restore.
    join_req(4'b1111, 1'b1, 4'b1100, 1'b1, 32'h100, 1'b0);
    join_req(4'b1111, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b0);
    // Empty stack: underflow flagged, captured mask echoed.
    join_req(4'b0110, 1'b0, 4'b0110, 1'b0, 32'h0, 1'b1);
    m_unf = 1'b1;

    // Reset while the join is waiting on stack read data.
    split_req(4'b1010, 4'b1000, 32'h200, 1'b0, 1'b1, 4'b1000, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_is_join = 1'b1; req_tmask = 4'b1010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("abort_pop", stk_pop, 0);
    chk("abort_resp", resp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_err", {err_ovf, err_unf}, 0);
    @(negedge clk);
    chk("abort_pop2", stk_pop, 0);
    chk("abort_stack_kept", 64'(stk_size), 2);
    rst_ni = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_resp", resp_valid, 0);
    join_req(4'b1010, 1'b1, 4'b0010, 1'b1, 32'h200, 1'b0);
    join_req(4'b1010, 1'b1, 4'b1010, 1'b0, 32'h0, 1'b0);

    // Random traffic against the reference rules.
    for (int n = 0; n < 150; n++) begin
      logic [NT-1:0] tm, tk, tmk, em;
      logic [PW-1:0] pc;
      logic          full, div, push;
      tm = NT'($urandom); tk = NT'($urandom); pc = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        join_model(tm);
      end else begin
        full = ($urandom_range(7, 0) == 0);
        tmk  = tm & tk;
        em   = tm & ~tk;
        div  = (tmk != 0) && (em != 0);
        push = div && !(full || stk_size >= CAP - 1);
        if (div && !push) m_ovf = 1'b1;
        split_req(tm, tk, pc, full, push, push ? tmk : tm, m_ovf);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
